// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback source,
// merges half-word writes, and serves two bypassed combinational read ports.
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int LINK_REG = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic [ADDR_W-1:0] reg_dst,
   input  logic              reg_wr,
   input  logic              wb_sel,
   input  logic              call,
   input  logic              high,
   input  logic              low,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_dst,
   output logic [DATA_W-1:0] wb_data
);

   localparam int NREG = 2 ** ADDR_W;
   localparam int HALF = DATA_W / 2;

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] old;
   logic [DATA_W-1:0] new_val;
   logic [ADDR_W-1:0] dst;
   logic              commit;

   always_comb begin
      src     = wb_sel ? mem_out : alu_out;
      dst     = reg_dst;
      if (call) begin
         src = pc_plus4;
         dst = ADDR_W'(LINK_REG);
      end
      old     = regs[dst];
      commit  = (reg_wr | call) & (dst != '0) & ~rst;
      // A call always writes the full link address regardless of high/low.
      if (call || (high == low))
         new_val = src;
      else if (high)
         new_val = {src[HALF-1:0], old[HALF-1:0]};
      else
         new_val = {old[DATA_W-1:HALF], src[HALF-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (commit) begin
         regs[dst] <= new_val;
      end
   end

   always_comb begin
      wb_valid = commit;
      wb_dst   = rst ? '0 : dst;
      wb_data  = commit ? new_val : '0;
   end

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (!rst && rd_addr_a != '0)
         rd_data_a = (commit && rd_addr_a == dst) ? new_val : regs[rd_addr_a];
      if (!rst && rd_addr_b != '0)
         rd_data_b = (commit && rd_addr_b == dst) ? new_val : regs[rd_addr_b];
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed cases plus random writeback traffic checked
// against an array model of the register file.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_out, alu_out, pc_plus4;
   logic [3:0]  reg_dst, rd_addr_a, rd_addr_b;
   logic        reg_wr, wb_sel, call, high, low;
   logic [31:0] rd_data_a, rd_data_b, wb_data;
   logic        wb_valid;
   logic [3:0]  wb_dst;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [16];
   logic        e_commit;
   logic [3:0]  e_dst;
   logic [31:0] e_new;

   wb_regfile dut (
      .clk(clk), .rst(rst), .mem_out(mem_out), .alu_out(alu_out), .pc_plus4(pc_plus4),
      .reg_dst(reg_dst), .reg_wr(reg_wr), .wb_sel(wb_sel), .call(call), .high(high), .low(low),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic sel, input logic c, input logic h, input logic l,
                        input logic [3:0] d, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [3:0] ra, input logic [3:0] rb);
      reg_wr = w; wb_sel = sel; call = c; high = h; low = l; reg_dst = d;
      alu_out = alu; mem_out = mem; pc_plus4 = pc; rd_addr_a = ra; rd_addr_b = rb;
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      if (a == 4'd0) return 32'h0;
      if (e_commit && a == e_dst) return e_new;
      return model[a];
   endfunction

   // Predict this cycle's writeback from the architectural rules, then compare.
   task automatic check_cycle(input string tag);
      logic [31:0] s, o;
      #1;
      s        = call ? pc_plus4 : (wb_sel ? mem_out : alu_out);
      e_dst    = call ? 4'd15 : reg_dst;
      e_commit = (reg_wr || call) && e_dst != 4'd0;
      o        = model[e_dst];
      if (call || high == low) e_new = s;
      else if (high)           e_new = (s << 16) | (o & 32'h0000_FFFF);
      else                     e_new = (o & 32'hFFFF_0000) | (s & 32'h0000_FFFF);
      chk({tag, ".wb_valid"}, {31'b0, wb_valid}, {31'b0, e_commit});
      chk({tag, ".wb_dst"}, {28'b0, wb_dst}, {28'b0, e_dst});
      chk({tag, ".wb_data"}, wb_data, e_commit ? e_new : 32'h0);
      chk({tag, ".rd_a"}, rd_data_a, exp_read(rd_addr_a));
      chk({tag, ".rd_b"}, rd_data_b, exp_read(rd_addr_b));
   endtask

   task automatic tick(input string tag);
      check_cycle(tag);
      @(posedge clk);
      if (e_commit) model[e_dst] = e_new;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      drive(1, 0, 0, 0, 0, 4'd3, 32'h1111_1111, 0, 0, 4'd3, 4'd0);
      @(negedge clk);
      #1;
      chk("rst.wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("rst.wb_data", wb_data, 32'h0);
      chk("rst.wb_dst", {28'b0, wb_dst}, 32'h0);
      chk("rst.rd_a", rd_data_a, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      drive(1, 0, 0, 0, 0, 4'd3, 32'h1234_5678, 0, 0, 4'd3, 4'd0);
      #1 chk("t2.bypass", rd_data_a, 32'h1234_5678);
      tick("t2");
      drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd3, 4'd3);
      #1 chk("t2.after", rd_data_a, 32'h1234_5678);

      drive(1, 0, 0, 0, 0, 4'd3, 32'hAAAA_BBBB, 0, 0, 4'd3, 4'd0);
      tick("t3.full");
      drive(1, 0, 0, 1, 0, 4'd3, 32'h0000_CDEF, 0, 0, 4'd3, 4'd0);
      #1 chk("t3.hi_bypass", rd_data_a, 32'hCDEF_BBBB);
      tick("t3.hi");
      drive(1, 1, 0, 0, 1, 4'd3, 32'h5555_5555, 32'hFFFF_0123, 0, 4'd0, 4'd3);
      tick("t3.lo");
      drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd3, 4'd0);
      #1 chk("t3.result", rd_data_a, 32'hCDEF_0123);

      drive(0, 0, 1, 1, 0, 4'd5, 32'h9999_9999, 0, 32'h0000_0040, 4'd15, 4'd5);
      #1 chk("t4.wb_dst", {28'b0, wb_dst}, 32'd15);
      tick("t4");
      drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd15, 4'd5);
      #1;
      chk("t4.link", rd_data_a, 32'h0000_0040);
      chk("t4.reg5", rd_data_b, 32'h0);

      drive(1, 0, 0, 0, 0, 4'd0, 32'hDEAD_BEEF, 0, 0, 4'd0, 4'd0);
      #1 chk("t5.valid", {31'b0, wb_valid}, 32'h0);
      tick("t5");
      #1 chk("t5.r0", rd_data_b, 32'h0);

      drive(1, 0, 0, 0, 1, 4'd3, 32'h1234_7777, 0, 0, 4'd3, 4'd3);
      for (int i = 0; i < 3; i++) begin
         tick("t6.hold");
         #1 chk("t6.held", rd_data_a, 32'hCDEF_7777);
      end
      drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd3, 4'd15);
      tick("t6.bubble");
      #1;
      chk("t6.bub_r3", rd_data_a, 32'hCDEF_7777);
      chk("t6.bub_r15", rd_data_b, 32'h0000_0040);

      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
               $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
               $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick("rand");
      end

      // Asynchronous reset between edges with a write pending: write is lost.
      drive(1, 0, 0, 0, 0, 4'd7, 32'h0000_0005, 0, 0, 4'd7, 4'd3);
      #2 rst = 1'b1;
      #1;
      chk("rst2.rd_a", rd_data_a, 32'h0);
      chk("rst2.rd_b", rd_data_b, 32'h0);
      chk("rst2.valid", {31'b0, wb_valid}, 32'h0);
      chk("rst2.wb_data", wb_data, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd7, 4'd3);
      #1;
      chk("rst2.r7", rd_data_a, 32'h0);
      chk("rst2.r3", rd_data_b, 32'h0);

      for (int n = 0; n < 100; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
               $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
               $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick("rand2");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
